// File: rtl/divide_by3_fsm_if.sv
// Output bundle of the clock divider: the strobe y and, when DIVBY3_PHASE_EN
// is defined, the current phase index.
interface divide_by3_fsm_if #(
    parameter int DIVISOR = 3
);
    localparam int PW = $clog2(DIVISOR);

    logic y;
`ifdef DIVBY3_PHASE_EN
    logic [PW-1:0] phase;

    modport master (output y, output phase);
    modport slave  (input  y, input  phase);
`else
    modport master (output y);
    modport slave  (input  y);
`endif
endinterface

// File: rtl/divide_by3_fsm.sv
// Moore divider: y strobes high for one cycle out of every DIVISOR cycles.
// Defining DIVBY3_PHASE_EN exposes the state register as out_if.phase.
module divide_by3_fsm #(
    parameter int DIVISOR = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    divide_by3_fsm_if.master       out_if
);
    localparam int PW = $clog2(DIVISOR);

    typedef enum logic [PW-1:0] {
        S0     = '0,
        S_LAST = PW'(DIVISOR - 1)
    } state_e;

    logic [PW-1:0] state_q;
    logic [PW-1:0] state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // The last legal state and any unused code both wrap to S0, so the
    // machine can never lock up in an unreachable encoding.
    always_comb begin
        state_d = S0;
        if (state_q < S_LAST) begin
            state_d = state_q + PW'(1);
        end
    end

    assign out_if.y = (state_q == S0);

`ifdef DIVBY3_PHASE_EN
    assign out_if.phase = state_q;
`endif

endmodule

// File: tb/tb_divide_by3_fsm.sv
// Bench for divide_by3_fsm: a DIVISOR=3 and a DIVISOR=5 instance checked
// every cycle against an edges-since-reset model, plus literal pins.
module tb_divide_by3_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  divide_by3_fsm_if #(.DIVISOR(3)) if3 ();
  divide_by3_fsm_if #(.DIVISOR(5)) if5 ();

  divide_by3_fsm #(.DIVISOR(3)) dut3 (.clk(clk), .reset(reset), .out_if(if3));
  divide_by3_fsm #(.DIVISOR(5)) dut5 (.clk(clk), .reset(reset), .out_if(if5));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count rising edges since the last reset edge; the strobe is high
  // whenever that count is a multiple of the divisor.
  int k3 = 0;
  int k5 = 0;
  bit model_valid = 1'b0;
  bit illegal3 = 1'b0;
  logic [6:0] exp_q[$];

  always @(posedge clk) begin
    logic [6:0] e;
    if (reset) begin
      k3 = 0;
      k5 = 0;
      model_valid = 1'b1;
    end else begin
      k3 = illegal3 ? 0 : k3 + 1;
      k5 = k5 + 1;
    end
    illegal3 = 1'b0;
    if (model_valid) begin
      e[6]   = ((k3 % 3) == 0);
      e[5:4] = 2'(k3 % 3);
      e[3]   = ((k5 % 5) == 0);
      e[2:0] = 3'(k5 % 5);
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y_div3", int'(if3.y), int'(e[6]));
      check("y_div5", int'(if5.y), int'(e[3]));
`ifdef DIVBY3_PHASE_EN
      check("phase_div3", int'(if3.phase), int'(e[5:4]));
      check("phase_div5", int'(if5.phase), int'(e[2:0]));
`endif
    end
  end

  task automatic set_reset(input logic v);
    #1 reset = v;
  endtask

  initial begin
    int pat3[10];
    int pat5[10];
    pat3 = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    pat5 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // Reset on the first edge, release at the following falling edge.
    @(posedge clk);
    #1;
    check("reset_y3", int'(if3.y), 1);
    check("reset_y5", int'(if5.y), 1);
`ifdef DIVBY3_PHASE_EN
    check("reset_phase3", int'(if3.phase), 0);
`endif
    @(negedge clk);
    set_reset(1'b0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pattern_y3", int'(if3.y), pat3[i]);
      check("pattern_y5", int'(if5.y), pat5[i]);
`ifdef DIVBY3_PHASE_EN
      check("pattern_phase5", int'(if5.phase), (i + 1) % 5);
`endif
    end

    // Held reset for five edges.
    set_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_y3", int'(if3.y), 1);
      check("held_y5", int'(if5.y), 1);
    end
    set_reset(1'b0);
    @(negedge clk);
    check("release_y3", int'(if3.y), 0);

    // Now in S1: reset for one edge, then again from S2.
    set_reset(1'b1);
    @(negedge clk);
    check("midrst_s1_y3", int'(if3.y), 1);
    set_reset(1'b0);
    repeat (2) @(negedge clk);
    check("before_s2_rst_y3", int'(if3.y), 0);
    set_reset(1'b1);
    @(negedge clk);
    check("midrst_s2_y3", int'(if3.y), 1);
    set_reset(1'b0);
    @(negedge clk);
    check("resume_s1_y3", int'(if3.y), 0);
    @(negedge clk);
    check("resume_s2_y3", int'(if3.y), 0);
    @(negedge clk);
    check("resume_s0_y3", int'(if3.y), 1);

    // Unused encoding must return to S0 on the next edge.
    #1 force dut3.state_q = 2'b11;
    #1 release dut3.state_q;
    illegal3 = 1'b1;
    #1;
    check("illegal_y3", int'(if3.y), 0);
    @(negedge clk);
    check("recover_y3", int'(if3.y), 1);
    @(negedge clk);
    check("recover_next_y3", int'(if3.y), 0);

    // Random reset pulses over long free-running stretches.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      set_reset(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    set_reset(1'b0);
    repeat (12) @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
